// File: rtl/seq_div_fsm.sv
// Sequential restoring divider: one quotient bit per SHIFT/SUB pair,
// start/ready handshake shared with the shift-add multiplier.
module seq_div_fsm #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero,
    output logic [1:0]   state
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        SUB   = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t cur, nxt;

    logic [N:0]    r;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;

    logic [N:0] diff;
    logic       fits;
    logic       last;
    logic       load_op;
    logic       load_dz;
    logic       finish;

    // R never exceeds 2D-1, so the MSB of diff is a reliable borrow flag
    assign diff  = r - {1'b0, d};
    assign fits  = ~diff[N];
    assign last  = (cnt == CW'(N - 1));
    assign state = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= IDLE;
        else     cur <= nxt;
    end

    always_comb begin
        nxt = cur;
        unique case (cur)
            IDLE, DONE: begin
                if (start) nxt = (divisor == '0) ? DONE : SHIFT;
            end
            SHIFT: nxt = SUB;
            SUB:   nxt = last ? DONE : SHIFT;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        load_op = 1'b0;
        load_dz = 1'b0;
        finish  = 1'b0;
        unique case (cur)
            IDLE, DONE: begin
                load_op = start && (divisor != '0);
                load_dz = start && (divisor == '0);
            end
            SUB:     finish = last;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            ready       <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (load_op) begin
            r           <= '0;
            q           <= dividend;
            d           <= divisor;
            cnt         <= '0;
            busy        <= 1'b1;
            ready       <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (load_dz) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            ready       <= 1'b1;
        end else if (cur == SHIFT) begin
            {r, q} <= {r, q} << 1;
        end else if (cur == SUB) begin
            if (fits) r <= diff;
            q[0] <= fits;
            cnt  <= cnt + 1'b1;
            if (finish) begin
                quotient  <= {q[N-1:1], fits};
                remainder <= fits ? diff[N-1:0] : r[N-1:0];
                busy      <= 1'b0;
                ready     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_div_fsm.sv
// Directed and sweep checks for seq_div_fsm (N=4) against a
// division reference computed in the bench.
module tb_seq_div_fsm;
    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       ready;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic [1:0] state;

    int n_checks;
    int n_fail;
    logic [3:0] prev_q;
    logic [3:0] prev_r;

    seq_div_fsm #(.N(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .busy(busy),
        .ready(ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_by_zero(div_by_zero),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves start high for exactly one posedge.
    task automatic issue(input logic [3:0] a, input logic [3:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after the accepting edge; counts edges to ready.
    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (!ready && lat < 30) begin
            chk({tag, "_busy"}, busy, 1);
            chk({tag, "_hold_q"}, quotient, prev_q);
            chk({tag, "_hold_r"}, remainder, prev_r);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] a,
                                input logic [3:0] b, input int lat);
        logic [3:0] eq, er;
        logic       edz;
        int         elat;
        if (b == 0) begin
            eq = 4'hF; er = a; edz = 1'b1; elat = 0;
        end else begin
            eq = a / b; er = a % b; edz = 1'b0; elat = 8;
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_state"}, state, 2'b11);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dz"}, div_by_zero, edz);
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic run_op(input string tag, input logic [3:0] a,
                          input logic [3:0] b, input int gap);
        int lat;
        repeat (gap) @(negedge clk);
        issue(a, b);
        wait_done(tag, lat);
        check_result(tag, a, b, lat);
    endtask

    initial begin
        logic [1:0] seq [9];
        int lat;
        seq = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3};
        n_checks = 0;
        n_fail   = 0;
        prev_q   = '0;
        prev_r   = '0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        rst      = 1'b0;
        #1 rst   = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dz", div_by_zero, 0);
        chk("rst_state", state, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_state", state, 0);

        // 13/4 with state trace
        start = 1'b1; dividend = 4'd13; divisor = 4'd4;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            chk($sformatf("trace_state_%0d", k), state, seq[k]);
            chk($sformatf("trace_busy_%0d", k), busy, (k < 8) ? 1 : 0);
            chk($sformatf("trace_ready_%0d", k), ready, (k == 8) ? 1 : 0);
        end
        check_result("d13_4", 4'd13, 4'd4, 8);

        run_op("d15_1", 4'd15, 4'd1, 1);
        run_op("d3_7", 4'd3, 4'd7, 2);
        run_op("d15_15", 4'd15, 4'd15, 0);
        run_op("d0_5", 4'd0, 4'd5, 1);
        run_op("d9_0", 4'd9, 4'd0, 1);
        run_op("d9_2", 4'd9, 4'd2, 0);

        // 14/3 with start toggled and operands changed mid-operation
        @(negedge clk);
        issue(4'd14, 4'd3);
        @(negedge clk);
        start = 1'b1; dividend = 4'd15; divisor = 4'd1;
        @(negedge clk);
        start = 1'b0; dividend = 4'd7; divisor = 4'd0;
        lat = 2;
        while (!ready && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        check_result("d14_3_ign", 4'd14, 4'd3, lat);

        // asynchronous reset in the middle of 11/2
        @(negedge clk);
        issue(4'd11, 4'd2);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_ready", ready, 0);
        chk("abort_q", quotient, 0);
        chk("abort_r", remainder, 0);
        chk("abort_dz", div_by_zero, 0);
        chk("abort_state", state, 0);
        @(negedge clk);
        rst = 1'b0;
        prev_q = '0;
        prev_r = '0;
        repeat (2) @(negedge clk);
        chk("post_rst_state", state, 0);
        chk("post_rst_ready", ready, 0);
        run_op("d11_2", 4'd11, 4'd2, 0);

        // all operand pairs with random gaps (gap 0 = back-to-back)
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_op($sformatf("sw_%0d_%0d", a, b), 4'(a), 4'(b),
                       int'($urandom_range(0, 2)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
